lector_ventana: RTL and testbench
=================================

Name: lector_ventana

Overview:
Read side of the convolver's sample register chain. Captures a sliding window of the last TAPS input samples, each captured with the same en/ent write semantics as the single sample register. On request, it streams the window out one tap per handshake, newest first, with a tap index for the MAC/coefficient stage. Sits between sample capture and the multiply-accumulate datapath.

Parameters:
ANCHO, 32, sample width in bits
TAPS, 8, window depth (number of taps), >= 2
IDX_W, 3, tap index width, equal to clog2(TAPS)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  write strobe: shift ent into the window this cycle
ent  input  ANCHO  incoming sample
inicio  input  1  start window readout
listo  input  1  downstream ready
sal  output  ANCHO  current tap sample (registered)
indice  output  IDX_W  tap index of sal, 0 = newest
valido  output  1  sal/indice valid
ultimo  output  1  valido and indice == TAPS-1
ocupado  output  1  readout in progress (state != REPOSO)
fin  output  1  one-cycle pulse after the last tap handshake
perdido  output  1  sticky flag: a write was dropped during readout

Behaviour:
- One clock domain. rst_n is asynchronous active-low. All state and outputs are registered except ultimo and ocupado, which decode registered state.
- Reset values: window w[0..TAPS-1]=0, sal=0, indice=0, valido=0, fin=0, perdido=0, state=REPOSO. Therefore ultimo=0 and ocupado=0.
- Window write: en=1 in REPOSO shifts w[i]<=w[i-1] for i=1..TAPS-1 and sets w[0]<=ent. The oldest sample is discarded. en=0 holds the window.
- en=1 while ocupado: the write is ignored, the window is frozen, and perdido<=1. perdido clears only on an accepted inicio or on reset.
- FSM states: REPOSO, LECTURA, FIN.
- REPOSO, inicio=1: go to LECTURA. Set valido<=1, indice<=0, sal<=w[0] and clear perdido. Latency is 1 cycle from the inicio edge to the first valid tap.
- REPOSO, inicio=1 and en=1 in the same cycle: the shift happens, and the readout snapshot includes the new sample, so sal<=ent.
- LECTURA: a handshake is valido && listo.
  - Handshake with indice<TAPS-1: indice<=indice+1 and sal<=w[indice+1].
  - Handshake with indice==TAPS-1: valido<=0, fin<=1, go to FIN.
  - listo=0: sal, indice and valido hold stable (no change while stalled).
- FIN: fin<=0, go to REPOSO. en writes are accepted again starting in FIN's following cycle (REPOSO). inicio in LECTURA or FIN is ignored and does not restart.
- Throughput: with listo held at 1, TAPS consecutive valid cycles, then fin in the next cycle. A full readout spans TAPS+2 cycles from inicio to REPOSO.
- indice never exceeds TAPS-1. No wrap occurs: readout terminates at TAPS-1.
- Reset asserted mid-readout aborts immediately. valido=0, no fin pulse, window cleared.
- Sample data passes through unmodified. No arithmetic or width change on ent/sal.

Test Plan:
1. Reset, then en=1 with ent=0x12,0xFF,0x51,0x30,0x08 on consecutive cycles, then inicio, listo=1 -> sal sequence 08,30,51,FF,12,00,00,00 with indice 0..7. ultimo=1 only on 00 at indice 7. fin pulses 1 cycle after, ocupado drops the next cycle.
2. Same window, listo toggled 1,0,0,1,... -> each tap held stable while listo=0, no tap skipped or repeated, fin only after the 8th handshake.
3. en=1, ent=0x55 during LECTURA -> window unchanged, perdido=1. A second readout still returns the pre-write window. perdido clears on that inicio.
4. In REPOSO, inicio=1 with en=1, ent=0xAA -> first tap sal=0xAA indice 0, followed by the previous w[0..6].
5. Assert rst_n=0 at indice=3 -> valido, sal, indice, perdido go to 0 immediately. No fin pulse. After release, a readout yields all 0x00.
6. inicio held high continuously through two readouts -> the second readout starts only from REPOSO, two cycles after the last handshake. No restart mid-stream.

Source files
------------

// File: rtl/lector_ventana_if.sv
// Handshake bundle between sample capture, the window reader and the MAC stage.
// The reader takes the slave view; whatever feeds it and consumes taps takes the master view.
interface lector_ventana_if #(
    parameter int ANCHO = 32,
    parameter int IDX_W = 3
);
    logic             en;
    logic [ANCHO-1:0] ent;
    logic             inicio;
    logic             listo;
    logic [ANCHO-1:0] sal;
    logic [IDX_W-1:0] indice;
    logic             valido;
    logic             ultimo;
    logic             ocupado;
    logic             fin;
    logic             perdido;

    modport slave (
        input  en, ent, inicio, listo,
        output sal, indice, valido, ultimo, ocupado, fin, perdido
    );

    modport master (
        output en, ent, inicio, listo,
        input  sal, indice, valido, ultimo, ocupado, fin, perdido
    );
endinterface

// File: rtl/lector_ventana.sv
// Sliding window of the last TAPS samples, streamed out newest-first one tap per
// handshake, with a tap index for the coefficient stage.
module lector_ventana #(
    parameter int ANCHO = 32,
    parameter int TAPS  = 8,
    parameter int IDX_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    lector_ventana_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        LECTURA = 2'd1,
        FIN     = 2'd2
    } estado_t;

    localparam logic [IDX_W-1:0] IDX_ULTIMO = IDX_W'(TAPS - 1);

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [ANCHO-1:0] r_ventana [TAPS];
    logic [ANCHO-1:0] r_sal;
    logic [ANCHO-1:0] w_sal_sig;
    logic [IDX_W-1:0] r_indice;
    logic [IDX_W-1:0] w_indice_sig;
    logic [IDX_W-1:0] w_indice_inc;
    logic             r_valido;
    logic             w_valido_sig;
    logic             r_fin;
    logic             w_fin_sig;
    logic             r_perdido;
    logic             w_perdido_sig;
    logic             w_escribir;
    logic             w_handshake;

    assign w_handshake  = r_valido && bus.listo;
    assign w_indice_inc = r_indice + {{(IDX_W-1){1'b0}}, 1'b1};

    // Next-state and next-output decode for the readout sequencer
    always_comb begin
        w_estado_sig  = r_estado;
        w_sal_sig     = r_sal;
        w_indice_sig  = r_indice;
        w_valido_sig  = r_valido;
        w_fin_sig     = r_fin;
        w_perdido_sig = r_perdido;
        w_escribir    = 1'b0;

        case (r_estado)
            REPOSO: begin
                w_escribir = bus.en;
                if (bus.inicio) begin
                    // A same-cycle write is part of the snapshot, so it becomes tap 0.
                    w_estado_sig  = LECTURA;
                    w_valido_sig  = 1'b1;
                    w_indice_sig  = {IDX_W{1'b0}};
                    w_sal_sig     = bus.en ? bus.ent : r_ventana[0];
                    w_perdido_sig = 1'b0;
                end else begin
                    w_estado_sig  = REPOSO;
                end
            end

            LECTURA: begin
                if (bus.en) begin
                    w_perdido_sig = 1'b1;
                end else begin
                    w_perdido_sig = r_perdido;
                end
                if (w_handshake) begin
                    if (r_indice == IDX_ULTIMO) begin
                        w_valido_sig = 1'b0;
                        w_fin_sig    = 1'b1;
                        w_estado_sig = FIN;
                    end else begin
                        w_indice_sig = w_indice_inc;
                        w_sal_sig    = r_ventana[w_indice_inc];
                    end
                end else begin
                    w_estado_sig = LECTURA;
                end
            end

            FIN: begin
                w_fin_sig    = 1'b0;
                w_estado_sig = REPOSO;
                if (bus.en) begin
                    w_perdido_sig = 1'b1;
                end else begin
                    w_perdido_sig = r_perdido;
                end
            end

            default: begin
                w_estado_sig = REPOSO;
                w_valido_sig = 1'b0;
                w_fin_sig    = 1'b0;
            end
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Registered tap outputs and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sal     <= {ANCHO{1'b0}};
            r_indice  <= {IDX_W{1'b0}};
            r_valido  <= 1'b0;
            r_fin     <= 1'b0;
            r_perdido <= 1'b0;
        end else begin
            r_sal     <= w_sal_sig;
            r_indice  <= w_indice_sig;
            r_valido  <= w_valido_sig;
            r_fin     <= w_fin_sig;
            r_perdido <= w_perdido_sig;
        end
    end

    // Sample window shift register, frozen whenever a readout is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_ventana[i] <= {ANCHO{1'b0}};
            end
        end else if (w_escribir) begin
            r_ventana[0] <= bus.ent;
            for (int i = 1; i < TAPS; i++) begin
                r_ventana[i] <= r_ventana[i-1];
            end
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                r_ventana[i] <= r_ventana[i];
            end
        end
    end

    assign bus.sal     = r_sal;
    assign bus.indice  = r_indice;
    assign bus.valido  = r_valido;
    assign bus.fin     = r_fin;
    assign bus.perdido = r_perdido;
    assign bus.ultimo  = r_valido && (r_indice == IDX_ULTIMO);
    assign bus.ocupado = (r_estado != REPOSO);

endmodule

// File: tb/tb_lector_ventana.sv
// Self-checking bench for lector_ventana: queue/array model checked every cycle,
// plus literal tap sequences for the directed scenarios.
module tb_lector_ventana;
    localparam int ANCHO = 32;
    localparam int TAPS  = 8;
    localparam int IDX_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lector_ventana_if #(.ANCHO(ANCHO), .IDX_W(IDX_W)) bus();

    lector_ventana #(.ANCHO(ANCHO), .TAPS(TAPS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nombre, act, exp, $time);
        end
    endtask

    // Model: the window as an array, a snapshot taken when readout starts,
    // and a phase (0 idle, 1 streaming, 2 done pulse).
    logic [31:0] mw   [TAPS];
    logic [31:0] snap [TAPS];
    int          fase;
    int          idx;
    logic        m_perd;
    logic [31:0] got_q [$];
    logic [31:0] mod_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) mw[i] = 32'h0;
            fase   = 0;
            idx    = 0;
            m_perd = 1'b0;
            chk("rst_valido",  bus.valido,  32'h0);
            chk("rst_fin",     bus.fin,     32'h0);
            chk("rst_ocupado", bus.ocupado, 32'h0);
            chk("rst_ultimo",  bus.ultimo,  32'h0);
            chk("rst_perdido", bus.perdido, 32'h0);
            chk("rst_sal",     bus.sal,     32'h0);
            chk("rst_indice",  bus.indice,  32'h0);
        end else begin
            chk("valido",  bus.valido,  (fase == 1));
            chk("ocupado", bus.ocupado, (fase != 0));
            chk("ultimo",  bus.ultimo,  (fase == 1 && idx == TAPS-1));
            chk("fin",     bus.fin,     (fase == 2));
            chk("perdido", bus.perdido, m_perd);
            if (fase == 1) begin
                chk("sal",    bus.sal,    snap[idx]);
                chk("indice", bus.indice, idx);
            end
            if (bus.valido && bus.listo) got_q.push_back(bus.sal);
            case (fase)
                0: begin
                    if (bus.en) begin
                        for (int i = TAPS-1; i > 0; i--) mw[i] = mw[i-1];
                        mw[0] = bus.ent;
                    end
                    if (bus.inicio) begin
                        for (int i = 0; i < TAPS; i++) snap[i] = mw[i];
                        idx    = 0;
                        fase   = 1;
                        m_perd = 1'b0;
                    end
                end
                1: begin
                    if (bus.en) m_perd = 1'b1;
                    if (bus.listo) begin
                        mod_q.push_back(snap[idx]);
                        if (idx == TAPS-1) fase = 2;
                        else idx++;
                    end
                end
                default: begin
                    if (bus.en) m_perd = 1'b1;
                    fase = 0;
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One full readout. patron=1 stalls with listo 1,0,0,1,0,0...; en0/ent0 write in the
    // inicio cycle; en_mid writes 0x55 during the stream.
    task automatic leer(input int patron, input logic en0, input logic [31:0] ent0, input logic en_mid);
        int k;
        got_q.delete();
        mod_q.delete();
        bus.en     = en0;
        bus.ent    = ent0;
        bus.inicio = 1'b1;
        step();
        bus.inicio = 1'b0;
        bus.en     = 1'b0;
        chk("perdido_clr", bus.perdido, 32'h0);
        k = 0;
        while (!bus.fin && k < 100) begin
            bus.listo = (patron == 1) ? ((k % 3) == 0) : 1'b1;
            bus.en    = (en_mid && k == 1);
            bus.ent   = 32'h55;
            step();
            k++;
        end
        bus.en = 1'b0;
        if (k >= 100) chk("fin_timeout", 32'h0, 32'h1);
        bus.listo = 1'b1;
        step();
    endtask

    task automatic cmp_q(input string n, input logic [31:0] e [TAPS]);
        chk({n, "_dut_len"}, got_q.size(), TAPS);
        chk({n, "_mod_len"}, mod_q.size(), TAPS);
        for (int i = 0; i < TAPS; i++) begin
            chk({n, "_dut_tap"}, (got_q.size() > i) ? got_q[i] : 32'hDEAD_BEEF, e[i]);
            chk({n, "_mod_tap"}, (mod_q.size() > i) ? mod_q[i] : 32'hDEAD_BEEF, e[i]);
        end
    endtask

    logic [31:0] e1   [TAPS];
    logic [31:0] e4   [TAPS];
    logic [31:0] e0   [TAPS];
    logic [31:0] sams [5];
    int          k;
    int          gap;

    initial begin
        e1   = '{32'h08, 32'h30, 32'h51, 32'hFF, 32'h12, 32'h00, 32'h00, 32'h00};
        e4   = '{32'hAA, 32'h08, 32'h30, 32'h51, 32'hFF, 32'h12, 32'h00, 32'h00};
        e0   = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00};
        sams = '{32'h12, 32'hFF, 32'h51, 32'h30, 32'h08};
        bus.en = 1'b0; bus.ent = 32'h0; bus.inicio = 1'b0; bus.listo = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: five writes then a full-speed readout
        for (int i = 0; i < 5; i++) begin
            bus.en = 1'b1; bus.ent = sams[i];
            step();
        end
        bus.en = 1'b0;
        bus.listo = 1'b1;
        leer(0, 1'b0, 32'h0, 1'b0);
        cmp_q("t1", e1);

        // 2: stalled readout
        leer(1, 1'b0, 32'h0, 1'b0);
        cmp_q("t2", e1);

        // 3: write dropped during readout, window preserved
        leer(0, 1'b0, 32'h0, 1'b1);
        cmp_q("t3a", e1);
        chk("t3_perdido_set", bus.perdido, 32'h1);
        leer(0, 1'b0, 32'h0, 1'b0);
        cmp_q("t3b", e1);

        // 4: write coinciding with inicio is tap 0
        leer(0, 1'b1, 32'hAA, 1'b0);
        cmp_q("t4", e4);

        // 5: reset at indice 3 aborts everything
        bus.inicio = 1'b1;
        step();
        bus.inicio = 1'b0;
        bus.en = 1'b1; bus.ent = 32'h77;
        step();
        bus.en = 1'b0;
        k = 0;
        while (!(bus.valido && bus.indice == 3'd3) && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) chk("t5_timeout", 32'h0, 32'h1);
        chk("t5_pre_perdido", bus.perdido, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_valido", bus.valido,  32'h0);
        chk("t5_sal",    bus.sal,     32'h0);
        chk("t5_indice", bus.indice,  32'h0);
        chk("t5_perdido", bus.perdido, 32'h0);
        chk("t5_fin",    bus.fin,     32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        leer(0, 1'b0, 32'h0, 1'b0);
        cmp_q("t5", e0);

        // 6: inicio held through two readouts
        for (int i = 1; i <= 3; i++) begin
            bus.en = 1'b1; bus.ent = i;
            step();
        end
        bus.en = 1'b0;
        bus.listo = 1'b1;
        bus.inicio = 1'b1;
        k = 0;
        while (!bus.fin && k < 100) begin step(); k++; end
        if (k >= 100) chk("t6_fin1_timeout", 32'h0, 32'h1);
        gap = 0;
        while (!bus.valido && gap < 10) begin step(); gap++; end
        chk("t6_restart_gap", gap, 32'd2);
        k = 0;
        while (!bus.fin && k < 100) begin step(); k++; end
        if (k >= 100) chk("t6_fin2_timeout", 32'h0, 32'h1);
        bus.inicio = 1'b0;
        repeat (3) step();
        chk("t6_idle_ocupado", bus.ocupado, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
